// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  // Loader states; encodings are visible on the debug state port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  // Frame start marker.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Framing overhead: sync + two length bytes before the payload, one checksum byte after.
  localparam int HDR_BYTES  = 3;
  localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/imem_loader_assembler.sv
// Byte-to-word assembler: packs bytes little-endian into a 32-bit word
// and keeps a running XOR checksum of every byte it is given.
module byte_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic        word_ready,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0] byte_cnt;

  // The next enabled byte lands in the top lane and completes the word.
  assign word_ready = (byte_cnt == 2'd3);

  // Lane counter, lane insert and checksum; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
      csum     <= 8'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      csum     <= 8'd0;
    end else if (enable) begin
      case (byte_cnt)
        2'd0:    word[7:0]   <= data;
        2'd1:    word[15:8]  <= data;
        2'd2:    word[23:16] <= data;
        default: word[31:24] <= data;
      endcase
      csum     <= csum ^ data;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream,
// writes whole words into instruction memory and holds the core in
// reset until a complete image with a matching checksum has landed.
//
// Byte handshake: a byte is taken on a rising clk edge where both
// rx_valid and rx_ready are high; rx_valid may drop at any time and the
// loader simply waits, holding any partially assembled word.
module imem_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = loader_pkg::SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [2:0]  state
);

  import loader_pkg::*;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t                state_q, state_next;
  logic                  ready_q;
  logic [7:0]            len_lo;
  logic [15:0]           n_q;
  logic [ADDR_WIDTH:0]   word_idx;
  logic                  accept;
  logic [15:0]           n_rx;
  logic [16:0]           idx_next;
  logic                  asm_clear;
  logic                  asm_enable;
  logic                  word_ready;
  logic [31:0]           word;
  logic [7:0]            csum;

  assign accept   = rx_valid && rx_ready;
  assign n_rx     = {rx_data, len_lo};
  assign idx_next = 17'(word_idx) + 17'd1;

  // Ready comes up one clock after reset leaves, and drops for the write cycle.
  assign rx_ready   = ready_q && (state_q != WRITE);
  assign imem_addr  = {{(30 - ADDR_WIDTH){1'b0}}, word_idx[ADDR_WIDTH-1:0], 2'b00};
  assign imem_wdata = word;
  assign state      = state_q;

  byte_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .enable     (asm_enable),
    .data       (rx_data),
    .word_ready (word_ready),
    .word       (word),
    .csum       (csum)
  );

  // Next-state decode and assembler controls.
  always_comb begin
    state_next = state_q;
    asm_clear  = 1'b0;
    asm_enable = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (accept && (rx_data == SYNC_BYTE)) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          asm_clear = 1'b1;
          if (n_rx == 16'd0)                 state_next = CSUM;
          else if ({1'b0, n_rx} > CAPACITY) state_next = ERROR;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          asm_enable = 1'b1;
          if (word_ready) state_next = WRITE;
        end
      end
      WRITE: begin
        if (idx_next == {1'b0, n_q}) state_next = CSUM;
        else                         state_next = DATA;
      end
      CSUM: begin
        if (accept) state_next = (rx_data == csum) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the post-reset ready enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_next;
      ready_q <= 1'b1;
    end
  end

  // Length capture and word index; the index restarts with each new length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo   <= 8'd0;
      n_q      <= 16'd0;
      word_idx <= '0;
    end else begin
      if ((state_q == LEN_LO) && accept) len_lo <= rx_data;
      if ((state_q == LEN_HI) && accept) begin
        n_q      <= n_rx;
        word_idx <= '0;
      end
      if (state_q == WRITE) word_idx <= word_idx + 1'b1;
    end
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we    <= (state_next == WRITE);
      core_reset <= (state_next != DONE);
      load_done  <= (state_next == DONE);
      load_error <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are built from word lists, the
// checksum and expected writes are derived from those words, and every
// observed write is matched against the expected queue.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [2:0]  state;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .state      (state)
  );

  // Clock and counters.
  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          write_cnt = 0;
  bit          gaps      = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: each write strobe is compared against the next expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      write_cnt++;
      if (exp_q.size() > 0) check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
      check("ready_in_write", {63'd0, rx_ready}, 64'd0);
    end
  end

  // Build frame_q from words[], queue the expected writes.
  task automatic make_frame(input bit bad);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    frame_q.delete();
    cs = 8'd0;
    n  = 16'(words.size());
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
      exp_q.push_back({(32'(i) << 2), w});
    end
    frame_q.push_back(bad ? ~cs : cs);
  endtask

  // Driver: present each byte only when ready, optional random idle gaps.
  task automatic send_bytes(input int cnt);
    int budget;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      budget = 0;
      while (!rx_ready && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!rx_ready) check("ready_timeout", {63'd0, rx_ready}, 64'd1);
      rx_data  = frame_q.pop_front();
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_state",      64'(state),      64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_we",         64'(imem_we),    64'd0);
    check("rst_addr",       64'(imem_addr),  64'd0);
    check("rst_wdata",      64'(imem_wdata), 64'd0);
    check("rst_done",       64'(load_done),  64'd0);
    check("rst_error",      64'(load_error), 64'd0);
    check("rst_ready",      64'(rx_ready),   64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(rx_ready), 64'd1);

    // Two-word frame; checksum 13^B3^10 = B0.
    words = '{32'h0000_0013, 32'h0010_00B3};
    make_frame(1'b0);
    check("s1_csum_byte", 64'(frame_q[11]), 64'hB0);
    send_bytes(7);
    check("s1_we_latency", 64'(imem_we),    64'd1);
    check("s1_addr0",      64'(imem_addr),  64'h0);
    check("s1_wdata0",     64'(imem_wdata), 64'h13);
    check("s1_core_held",  64'(core_reset), 64'd1);
    send_bytes(frame_q.size());
    check("s1_done",       64'(load_done),  64'd1);
    check("s1_core_rel",   64'(core_reset), 64'd0);
    check("s1_no_error",   64'(load_error), 64'd0);
    check("s1_writes",     64'(write_cnt),  64'd2);

    // Bad checksum, then a good frame recovers.
    make_frame(1'b1);
    send_bytes(frame_q.size());
    check("s2_error",      64'(load_error), 64'd1);
    check("s2_core_held",  64'(core_reset), 64'd1);
    check("s2_not_done",   64'(load_done),  64'd0);
    check("s2_writes",     64'(write_cnt),  64'd4);
    make_frame(1'b0);
    send_bytes(frame_q.size());
    check("s2_recover",    64'(load_done),  64'd1);
    check("s2_err_clear",  64'(load_error), 64'd0);

    // Leading garbage in IDLE is discarded.
    do_reset();
    check("s3_done_clr",   64'(load_done),  64'd0);
    make_frame(1'b0);
    frame_q.push_front(8'h5A);
    frame_q.push_front(8'hFF);
    frame_q.push_front(8'h00);
    send_bytes(frame_q.size());
    check("s3_done",       64'(load_done),  64'd1);
    check("s3_writes",     64'(write_cnt),  64'd8);

    // Oversized length 0x0101 is rejected right after LEN_HI.
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h01);
    frame_q.push_back(8'h01);
    send_bytes(3);
    check("s4_error",      64'(load_error), 64'd1);
    check("s4_state",      64'(state),      64'd7);
    check("s4_writes",     64'(write_cnt),  64'd8);

    // Empty image: N = 0 and checksum 00.
    words.delete();
    make_frame(1'b0);
    send_bytes(frame_q.size());
    check("s6_done",       64'(load_done),  64'd1);
    check("s6_core_rel",   64'(core_reset), 64'd0);
    check("s6_writes",     64'(write_cnt),  64'd8);

    // Sync byte inside the payload is plain data.
    words = '{32'hA5A5_A5A5};
    make_frame(1'b0);
    send_bytes(frame_q.size());
    check("sync_data_done",   64'(load_done), 64'd1);
    check("sync_data_writes", 64'(write_cnt), 64'd9);

    // Full memory: 256 words, last one at 0x3FC.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({8'(i), 8'(~i), 8'(i + 3), 8'hC3});
    make_frame(1'b0);
    send_bytes(frame_q.size());
    check("full_done",     64'(load_done),     64'd1);
    check("full_writes",   64'(write_cnt),     64'd265);
    check("full_exp_left", 64'(exp_q.size()),  64'd0);

    // Random stalls, then an asynchronous reset after five data bytes.
    do_reset();
    gaps  = 1'b1;
    words = '{32'h4433_2211, 32'h8877_6655};
    make_frame(1'b0);
    send_bytes(8);
    check("s5_one_write",  64'(write_cnt),  64'd266);
    #2 reset = 1'b1;
    #1;
    check("s5_rst_state",  64'(state),      64'd0);
    check("s5_rst_core",   64'(core_reset), 64'd1);
    check("s5_rst_we",     64'(imem_we),    64'd0);
    check("s5_rst_ready",  64'(rx_ready),   64'd0);
    exp_q.delete();
    frame_q.delete();
    gaps = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s5_ready_back", 64'(rx_ready),   64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
